// File: rtl/fb_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fb_wr_arbiter
//
// Round-robin arbiter that shares the framebuffer pixel-write port between
// several pixel producers (index 0 = clear engine, 1 = rasterizer). A grant
// is held for at most MAX_RUN consecutive beats. The AXI master then sees
// runs of sequential addresses that it can turn into bursts. Each accepted
// beat passes through one output register before the framebuffer port.
//
// Optional feature macro: FB_WR_ARB_STATS_EN
//   When defined, a per-requester 32-bit accepted-beat counter is added and
//   exported on stat_count. Arbitration behaviour does not change.
//
// Ports:
//   clk          single clock for all logic
//   rst          synchronous, active-high reset
//   req_valid    [N_REQ]         per-requester beat valid
//   req_ready    [N_REQ]         per-requester beat accept
//   req_addr     [N_REQ*ADDR_W]  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data     [N_REQ*DATA_W]  packed data, same packing
//   fb_wr_valid  registered beat valid to the framebuffer master
//   fb_wr_ready  framebuffer master accept
//   fb_wr_addr   [ADDR_W]        registered beat address
//   fb_wr_data   [DATA_W]        registered beat data
//   grant_id     [ID_W]          current / last granted requester
//   idle         arbiter idle, output register empty, no request pending
//   stat_count   [N_REQ*32]      accepted-beat counters (FB_WR_ARB_STATS_EN only)
// ----------------------------------------------------------------------------
module fb_wr_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_RUN = 16,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    fb_wr_valid,
  input  logic                    fb_wr_ready,
  output logic [ADDR_W-1:0]       fb_wr_addr,
  output logic [DATA_W-1:0]       fb_wr_data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    idle
`ifdef FB_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]     stat_count
`endif
);

  localparam int RUN_W = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              ov_q, ov_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ID_W-1:0]   sel_id;
  logic              slot_free;
  logic              xfer;
  logic              run_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // --------------------------------------------------------------------------
  // Round-robin pick: the search order is last+1, last+2, ... (mod N_REQ).
  // The loop runs from the farthest candidate down to the nearest one, so the
  // nearest asserted requester overwrites the others and no early exit is
  // needed.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    sel_id = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % N_REQ]) begin
        sel_id = ID_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  // The output register can take a beat when it is empty or is draining now.
  assign slot_free = !ov_q || fb_wr_ready;
  assign xfer      = (state_q == S_GRANT) && req_valid[gnt_q] && slot_free;
  assign run_last  = (run_q == RUN_W'(MAX_RUN - 1));
  assign sel_addr  = req_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gnt_q)*DATA_W +: DATA_W];

  // --------------------------------------------------------------------------
  // FSM state register and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so all
    // registers update together from values sampled before the edge.
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      run_q   <= '0;
      ov_q    <= 1'b0;
      // NOTE: the beat payload registers are reset even though ov_q alone
      // qualifies them, because their reset value is visible on the ports.
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      run_q   <= run_d;
      ov_q    <= ov_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    run_d   = run_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_GRANT;
          gnt_d   = sel_id;
          run_d   = '0;
        end
      end
      S_GRANT: begin
        if (xfer) begin
          run_d = run_q + 1'b1;
        end
        // Release on a full run or as soon as the owner stops presenting
        // beats, so another producer is not starved by a stalled one.
        if (!req_valid[gnt_q] || (xfer && run_last)) begin
          state_d = S_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (state_q == S_GRANT) begin
      req_ready[gnt_q] = slot_free;
    end
  end

  assign grant_id    = gnt_q;
  assign idle        = (state_q == S_IDLE) && !ov_q && !(|req_valid);
  assign fb_wr_valid = ov_q;
  assign fb_wr_addr  = addr_q;
  assign fb_wr_data  = data_q;

  // --------------------------------------------------------------------------
  // Output register next state. A load in the same cycle as a drain keeps
  // ov set and replaces the beat.
  // --------------------------------------------------------------------------
  always_comb begin
    ov_d   = ov_q;
    addr_d = addr_q;
    data_d = data_q;
    if (xfer) begin
      ov_d   = 1'b1;
      addr_d = sel_addr;
      data_d = sel_data;
    end else if (ov_q && fb_wr_ready) begin
      ov_d   = 1'b0;
    end
  end

`ifdef FB_WR_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Accepted-beat counters. They wrap naturally at 2^32.
  // --------------------------------------------------------------------------
  logic [31:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (xfer) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + 32'd1;
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_count[i*32 +: 32] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fb_wr_arbiter
//
// Directed bench for fb_wr_arbiter (N_REQ=2, MAX_RUN=16). Inputs change on
// the falling edge and outputs are sampled 1 time unit later. The DUT
// therefore registers on the rising edge between two sample points. A
// monitor records every beat that leaves on the framebuffer port. The
// recorded sequence is compared against the beats the producers issued.
// ----------------------------------------------------------------------------
module tb_fb_wr_arbiter;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_RUN = 16;
  localparam int LOG_LEN = 128;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    fb_wr_valid;
  logic                    fb_wr_ready;
  logic [ADDR_W-1:0]       fb_wr_addr;
  logic [DATA_W-1:0]       fb_wr_data;
  logic [0:0]              grant_id;
  logic                    idle;
`ifdef FB_WR_ARB_STATS_EN
  logic [N_REQ*32-1:0]     stat_count;
`endif

  fb_wr_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_RUN (MAX_RUN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .fb_wr_valid (fb_wr_valid),
    .fb_wr_ready (fb_wr_ready),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .grant_id    (grant_id),
    .idle        (idle)
`ifdef FB_WR_ARB_STATS_EN
    ,
    .stat_count  (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producer model: requester i issues total[i] beats starting at cycle
  // start[i]. Beat k has address base[i]+4k.
  int          total [N_REQ];
  int          sent  [N_REQ];
  int          start [N_REQ];
  logic [31:0] base  [N_REQ];
  bit          rdy_pat [LOG_LEN];

  logic [1:0]  rdy_log [LOG_LEN];
  logic [0:0]  gid_log [LOG_LEN];
  logic        fbv_log [LOG_LEN];

  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];

  always @(posedge clk) begin
    if (!rst && fb_wr_valid && fb_wr_ready) begin
      got_q.push_back({fb_wr_addr, fb_wr_data});
    end
  end

  function automatic logic [31:0] beat_data(input int i, input int k);
    return 32'hD000_0000 | (32'(i) << 16) | 32'(k);
  endfunction

  function automatic logic [63:0] beat(input int i, input int k);
    return {base[i] + 32'(4*k), beat_data(i, k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      check($sformatf("%s_beat%0d", tag, j), got_q[j], exp_q[j]);
    end
  endtask

  // Ends on a falling edge with rst released and all stimulus cleared.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    req_valid   = '0;
    fb_wr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < N_REQ; i++) begin
      total[i] = 0;
      sent[i]  = 0;
      start[i] = 0;
      base[i]  = 32'h0;
    end
    for (int c = 0; c < LOG_LEN; c++) rdy_pat[c] = 1'b1;
  endtask

  // One iteration per clock: drive, sample, account for handshakes.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i]            = (c >= start[i]) && (sent[i] < total[i]);
        req_addr[i*ADDR_W +: ADDR_W] = base[i] + 32'(4*sent[i]);
        req_data[i*DATA_W +: DATA_W] = beat_data(i, sent[i]);
      end
      fb_wr_ready = rdy_pat[c];
      #1;
      rdy_log[c] = req_ready;
      gid_log[c] = grant_id;
      fbv_log[c] = fb_wr_valid;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) sent[i]++;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] vec0, vec1, vecv;

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    fb_wr_ready = 1'b1;

    // ---------------- reset values ----------------
    do_reset();
    #1;
    check("rst_fb_valid",  64'(fb_wr_valid), 64'd0);
    check("rst_fb_addr",   64'(fb_wr_addr),  64'd0);
    check("rst_fb_data",   64'(fb_wr_data),  64'd0);
    check("rst_req_ready", 64'(req_ready),   64'd0);
    check("rst_grant_id",  64'(grant_id),    64'd0);
    check("rst_idle",      64'(idle),        64'd1);

    // ---------------- single requester, 20 beats ----------------
    // ready: cycles 1-16 (beats 0-15), 17 IDLE gap, 18-21 (beats 16-19),
    // 22 GRANT with valid low (ready high, release).
    // fb_wr_valid: cycles 2-17, gap at 18, cycles 19-22.
    do_reset();
    total[0] = 20;
    base[0]  = 32'h0000_1000;
    run_cycles(26);
    vec0 = '0; vec1 = '0; vecv = '0;
    for (int c = 0; c < 26; c++) begin
      vec0[c] = rdy_log[c][0];
      vec1[c] = rdy_log[c][1];
      vecv[c] = fbv_log[c];
    end
    check("single_ready0",  64'(vec0), 64'h007D_FFFE);
    check("single_ready1",  64'(vec1), 64'h0000_0000);
    check("single_fbvalid", 64'(vecv), 64'h007B_FFFC);
    #1;
    check("single_idle_end", 64'(idle), 64'd1);
    for (int k = 0; k < 20; k++) exp_q.push_back(beat(0, k));
    check_seq("single");

    // ---------------- contention, both continuously valid ----------------
    // Grants: 0 at cycles 1-16, 1 at 18-33, 0 at 35-50, 1 at 52-67.
    do_reset();
    total[0] = 32; base[0] = 32'h0000_1000;
    total[1] = 32; base[1] = 32'h0000_8000;
    run_cycles(72);
    check("cont_gid_run0",   64'(gid_log[1]),  64'd0);
    check("cont_gid_run1",   64'(gid_log[18]), 64'd1);
    check("cont_gid_run2",   64'(gid_log[35]), 64'd0);
    check("cont_gid_run3",   64'(gid_log[52]), 64'd1);
    check("cont_rdy_first0", 64'(rdy_log[1]),  64'h1);
    check("cont_rdy_last0",  64'(rdy_log[16]), 64'h1);
    check("cont_rdy_gap0",   64'(rdy_log[17]), 64'h0);
    check("cont_rdy_first1", 64'(rdy_log[18]), 64'h2);
    check("cont_rdy_last1",  64'(rdy_log[33]), 64'h2);
    check("cont_rdy_gap1",   64'(rdy_log[34]), 64'h0);
    check("cont_rdy_gap2",   64'(rdy_log[51]), 64'h0);
    for (int k = 0;  k < 16; k++) exp_q.push_back(beat(0, k));
    for (int k = 0;  k < 16; k++) exp_q.push_back(beat(1, k));
    for (int k = 16; k < 32; k++) exp_q.push_back(beat(0, k));
    for (int k = 16; k < 32; k++) exp_q.push_back(beat(1, k));
    check_seq("cont");

    // ---------------- backpressure ----------------
    // fb_wr_ready from cycle 2: 1,0,0,1 repeating. ov is set from cycle 2,
    // so ready follows fb_wr_ready: cycles 1,2,5,6,9,10 high.
    do_reset();
    total[0] = 6; base[0] = 32'h0000_2000;
    for (int c = 2; c < LOG_LEN; c++) begin
      rdy_pat[c] = !(((c - 2) % 4 == 1) || ((c - 2) % 4 == 2));
    end
    run_cycles(20);
    vec0 = '0;
    for (int c = 0; c <= 10; c++) vec0[c] = rdy_log[c][0];
    check("bp_ready_pattern", 64'(vec0), 64'h0000_0666);
    check("bp_hold_valid_c3", 64'(fbv_log[3]), 64'd1);
    check("bp_hold_valid_c4", 64'(fbv_log[4]), 64'd1);
    for (int k = 0; k < 6; k++) exp_q.push_back(beat(0, k));
    check_seq("bp");

    // ---------------- early release ----------------
    // Requester 1 is alone at cycle 0 and wins, sends 3 beats (cycles 1-3),
    // then drops valid at cycle 4. Cycle 5 is IDLE, requester 0 owns cycle 6.
    do_reset();
    total[1] = 3; base[1] = 32'h0000_8000;
    total[0] = 4; base[0] = 32'h0000_3000; start[0] = 2;
    run_cycles(14);
    check("early_gid_c1",  64'(gid_log[1]), 64'd1);
    check("early_rdy_c4",  64'(rdy_log[4]), 64'h2);
    check("early_rdy_c5",  64'(rdy_log[5]), 64'h0);
    check("early_gid_c5",  64'(gid_log[5]), 64'd1);
    check("early_gid_c6",  64'(gid_log[6]), 64'd0);
    check("early_rdy_c6",  64'(rdy_log[6]), 64'h1);
    for (int k = 0; k < 3; k++) exp_q.push_back(beat(1, k));
    for (int k = 0; k < 4; k++) exp_q.push_back(beat(0, k));
    check_seq("early");

    // ---------------- reset mid-run ----------------
    // Beats 0-5 are accepted in cycles 1-6. Beats 0-4 drain; beat 5 sits in
    // the output register when reset hits and must be discarded.
    do_reset();
    total[0] = 20; base[0] = 32'h0000_4000;
    run_cycles(7);
    check("mid_sent", 64'(sent[0]), 64'd6);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_fb_valid",  64'(fb_wr_valid),  64'd0);
    check("mid_req_ready", 64'(req_ready),    64'd0);
    check("mid_idle",      64'(idle),         64'd1);
    check("mid_drained",   64'(got_q.size()), 64'd5);
    got_q.delete();
    for (int i = 0; i < N_REQ; i++) begin
      sent[i]  = 0;
      total[i] = 2;
    end
    base[1] = 32'h0000_9000;
    run_cycles(12);
    check("mid_gid_first", 64'(gid_log[1]), 64'd0);
    check("mid_rdy_first", 64'(rdy_log[1]), 64'h1);
    for (int k = 0; k < 2; k++) exp_q.push_back(beat(0, k));
    for (int k = 0; k < 2; k++) exp_q.push_back(beat(1, k));
    check_seq("mid_after");

`ifdef FB_WR_ARB_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    total[0] = 37; base[0] = 32'h0000_1000;
    total[1] = 12; base[1] = 32'h0000_8000;
    run_cycles(90);
    check("stats_req0", 64'(stat_count[31:0]),  64'd37);
    check("stats_req1", 64'(stat_count[63:32]), 64'd12);
    do_reset();
    #1;
    check("stats_rst_req0", 64'(stat_count[31:0]),  64'd0);
    check("stats_rst_req1", 64'(stat_count[63:32]), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
